pcs_enc4b5b: RTL and testbench
==============================

# pcs_enc4b5b

Parametrised 100BASE-X PCS transmit encoder: converts MII nibbles (1 or 2 nibbles per clock) into 4B/5B code groups, replacing the first preamble byte with J/K, appending T/R, and mapping TX_ER to H. Enforces a minimum inter-packet gap by dropping frames that start too early, and counts transmitted frames. Sits between the MAC/frame generator and the serializer/NRZI line driver.

## Interface
- LANES, 1, nibbles per clock (1 or 2); lane 0 = earlier nibble, bits [3:0]
- MIN_IPG, 24, minimum idle code groups between R and the next J
- i_clk  in  1  clock
- i_res  in  1  reset; synchronous, active-high
- i_tx_en  in  1  frame enable (MII TX_EN)
- i_tx_er  in  1  transmit error (MII TX_ER), applies to all lanes of the cycle
- i_data  in  4*LANES  nibbles; lane n at [4n+3:4n]
- o_data  out  5*LANES  code groups; lane n at [5n+4:5n], bit 4 transmitted first
- o_busy  out  1  high in any state other than IDLE
- o_drop  out  1  one-cycle pulse when a frame is dropped for IPG violation
- o_frame_cnt  out  16  frames started (J emitted), wraps 0xFFFF→0

## Operation
- Code groups: data 0..F = 11110,01001,10100,10101,01010,01011,01110,01111,10010,10011,10110,10111,11010,11011,11100,11101; I=11111, J=11000, K=10001, T=01101, R=00111, H=00100.
- Frame start = i_tx_en high while previous sampled i_tx_en low. Previous-enable register resets to 1: tx_en high at reset release is ignored until it goes low.
- States: IDLE, SSD_K (LANES=1 only), DATA, ESD_R (LANES=1 only), IPG, DROP.
- IDLE: emit I. On frame start: if gap counter ≥ MIN_IPG → emit J (LANES=1, go SSD_K) or {K,J} lanes {1,0} (LANES=2, go DATA); increment o_frame_cnt. Else → DROP, pulse o_drop, emit I.
- SSD_K: tx_en high → emit K, go DATA; tx_en low → emit T, go ESD_R.
- DATA: tx_en high → encode each lane; i_tx_er high → every lane emits H. tx_en low → LANES=1: emit T, go ESD_R; LANES=2: emit {R,T}, go IPG.
- ESD_R: emit R, go IPG.
- IPG/DROP: emit I. DROP exits when tx_en low → IPG. IPG → IDLE when counter ≥ MIN_IPG; a frame start seen in IPG behaves as in IDLE (drop if counter < MIN_IPG).
- Gap counter: cleared on the cycle R is emitted; +LANES per cycle emitting only I (including DROP); saturates at MIN_IPG; width $clog2(MIN_IPG+LANES+1); resets to MIN_IPG so the first frame is accepted. MIN_IPG=0 disables dropping.
- i_tx_er outside DATA is ignored. LANES=2 frames are whole bytes; tx_en is sampled once per cycle.

## Timing
- All outputs registered; o_data reflects inputs sampled on the previous edge (1-cycle latency).
- Reset values: o_data all lanes I (11111), o_busy 0, o_drop 0, o_frame_cnt 0, state IDLE.
- Reset mid-frame: next cycle outputs I; no T/R emitted; a new frame needs tx_en low→high.
- LANES=1 frame of N nibbles (N≥2): J, K, N−2 data, T, R = N+2 code groups.
- Minimum legal restart (LANES=1): frame start on the cycle after MIN_IPG idle code groups following R.

## Configuration
- PCS_ENC4B5B_NRZI_EN defined: o_data carries NRZI-coded bits (line toggles on each 1, in transmit order lane 0 bit 4 first); running line-state register resets to 0; adds one pipeline stage (latency 2 cycles, o_data resets to 0). o_busy/o_drop/o_frame_cnt delayed to stay aligned.
- Undefined: o_data is NRZ code groups, latency 1.

## Test plan
- LANES=1, reset then 16-nibble frame 5,5,…,5,D → J,K,13×01011,11011,T,R, then I; o_frame_cnt=1.
- LANES=1, i_tx_er high on data nibble 6 → that code group is 00100, others unchanged.
- LANES=2, 8-byte frame → {K,J}, 7 data bytes, {R,T}; o_busy high 9 cycles.
- MIN_IPG=24, LANES=1, second frame starts 10 cycles after R → o_drop pulses once, o_data stays I for whole frame, o_frame_cnt unchanged; frame starting ≥24 idles after that drop's end is sent.
- i_tx_en held high across reset release → I until tx_en low→high; assert i_res mid-DATA → I on next cycle, no T/R.
- With PCS_ENC4B5B_NRZI_EN: J,K from idle line → bit stream matches NRZI of 11000 10001, latency 2.

Source files
------------

// File: rtl/pcs_enc4b5b.sv
// -----------------------------------------------------------------------------
// pcs_enc4b5b -- 100BASE-X PCS transmit encoder (MII nibbles -> 4B/5B).
//
// Replaces the first preamble byte with J/K, appends T/R after the frame,
// maps TX_ER to H, drops frames that start inside the minimum inter-packet
// gap, and counts frames that are actually started (J emitted).
//
// Parameters:
//   LANES    nibbles per clock (1 or 2); lane 0 is the earlier nibble
//   MIN_IPG  minimum idle code groups between R and the next J (0 = no drop)
//
// Ports:
//   i_clk         clock
//   i_res         synchronous active-high reset
//   i_tx_en       MII TX_EN
//   i_tx_er       MII TX_ER, applies to every lane of the cycle
//   i_data        nibbles, lane n at [4n+3:4n]
//   o_data        code groups, lane n at [5n+4:5n], bit 4 transmitted first
//   o_busy        high whenever the encoder is not in IDLE
//   o_drop        one-cycle pulse when a frame is dropped for IPG violation
//   o_frame_cnt   frames started, wraps 0xFFFF -> 0
//
// Configuration macro:
//   PCS_ENC4B5B_NRZI_EN  when defined, o_data carries NRZI-coded bits through
//                        one extra pipeline stage (latency 2); the status
//                        outputs are delayed by the same stage.
// -----------------------------------------------------------------------------
module pcs_enc4b5b #(
    parameter int LANES   = 1,
    parameter int MIN_IPG = 24
) (
    input  logic                 i_clk,
    input  logic                 i_res,
    input  logic                 i_tx_en,
    input  logic                 i_tx_er,
    input  logic [4*LANES-1:0]   i_data,
    output logic [5*LANES-1:0]   o_data,
    output logic                 o_busy,
    output logic                 o_drop,
    output logic [15:0]          o_frame_cnt
);

    localparam int CW = $clog2(MIN_IPG + LANES + 1);
    localparam logic [CW-1:0] GAP_MAX  = CW'(MIN_IPG);
    localparam logic [CW-1:0] GAP_STEP = CW'(LANES);

    localparam logic [4:0] C_I = 5'b11111;
    localparam logic [4:0] C_J = 5'b11000;
    localparam logic [4:0] C_K = 5'b10001;
    localparam logic [4:0] C_T = 5'b01101;
    localparam logic [4:0] C_R = 5'b00111;
    localparam logic [4:0] C_H = 5'b00100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SSD_K,
        S_DATA,
        S_ESD_R,
        S_IPG,
        S_DROP
    } state_t;

    function automatic logic [4:0] f_enc(input logic [3:0] nib);
        logic [4:0] code;
        case (nib)
            4'h0: code = 5'b11110;
            4'h1: code = 5'b01001;
            4'h2: code = 5'b10100;
            4'h3: code = 5'b10101;
            4'h4: code = 5'b01010;
            4'h5: code = 5'b01011;
            4'h6: code = 5'b01110;
            4'h7: code = 5'b01111;
            4'h8: code = 5'b10010;
            4'h9: code = 5'b10011;
            4'hA: code = 5'b10110;
            4'hB: code = 5'b10111;
            4'hC: code = 5'b11010;
            4'hD: code = 5'b11011;
            4'hE: code = 5'b11100;
            default: code = 5'b11101;
        endcase
        return code;
    endfunction

    state_t               r_state;
    logic                 r_prev_en;
    logic [CW-1:0]        r_gap;
    logic [5*LANES-1:0]   r_code;
    logic                 r_busy;
    logic                 r_drop;
    logic [15:0]          r_frame_cnt;

    state_t               w_state_nxt;
    logic [5*LANES-1:0]   w_code_nxt;
    logic [CW-1:0]        w_gap_nxt;
    logic [CW-1:0]        w_gap_inc;
    logic                 w_drop_nxt;
    logic                 w_cnt_inc;
    logic                 w_idle_only;
    logic                 w_gap_clr;
    logic                 w_start;
    logic                 w_gap_ok;

    // The previous-enable register resets high, so a tx_en already high at
    // reset release is not mistaken for a frame start.
    assign w_start   = i_tx_en & ~r_prev_en;
    assign w_gap_ok  = (r_gap >= GAP_MAX);
    assign w_gap_inc = r_gap + GAP_STEP;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_code_nxt  = {LANES{C_I}};
        w_drop_nxt  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_idle_only = 1'b0;
        w_gap_clr   = 1'b0;

        case (r_state)
            S_IDLE, S_IPG: begin
                w_idle_only = 1'b1;
                if (w_start) begin
                    if (w_gap_ok) begin
                        w_idle_only = 1'b0;
                        w_cnt_inc   = 1'b1;
                        // Lane 0 carries J, lane 1 (if present) carries K.
                        for (int l = 0; l < LANES; l++) begin
                            w_code_nxt[5*l +: 5] = (l == 0) ? C_J : C_K;
                        end
                        w_state_nxt = (LANES == 1) ? S_SSD_K : S_DATA;
                    end else begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_DROP;
                    end
                end else if (r_state == S_IPG && w_gap_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_SSD_K: begin
                if (i_tx_en) begin
                    w_code_nxt[4:0] = C_K;
                    w_state_nxt     = S_DATA;
                end else begin
                    w_code_nxt[4:0] = C_T;
                    w_state_nxt     = S_ESD_R;
                end
            end

            S_DATA: begin
                if (i_tx_en) begin
                    for (int l = 0; l < LANES; l++) begin
                        w_code_nxt[5*l +: 5] = i_tx_er ? C_H : f_enc(i_data[4*l +: 4]);
                    end
                end else if (LANES == 1) begin
                    w_code_nxt[4:0] = C_T;
                    w_state_nxt     = S_ESD_R;
                end else begin
                    // Two-lane delimiter: T then R in the same cycle.
                    for (int l = 0; l < LANES; l++) begin
                        w_code_nxt[5*l +: 5] = (l == 0) ? C_T : C_R;
                    end
                    w_gap_clr   = 1'b1;
                    w_state_nxt = S_IPG;
                end
            end

            S_ESD_R: begin
                w_code_nxt[4:0] = C_R;
                w_gap_clr       = 1'b1;
                w_state_nxt     = S_IPG;
            end

            S_DROP: begin
                w_idle_only = 1'b1;
                if (!i_tx_en) begin
                    w_state_nxt = S_IPG;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Gap counter: cleared with R, counts idle code groups, saturates.
        if (w_gap_clr) begin
            w_gap_nxt = '0;
        end else if (w_idle_only) begin
            w_gap_nxt = (w_gap_inc >= GAP_MAX) ? GAP_MAX : w_gap_inc;
        end else begin
            w_gap_nxt = r_gap;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (i_res) begin
            r_state     <= S_IDLE;
            r_prev_en   <= 1'b1;
            r_gap       <= GAP_MAX;
            r_code      <= {LANES{C_I}};
            r_busy      <= 1'b0;
            r_drop      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_en   <= i_tx_en;
            r_gap       <= w_gap_nxt;
            r_code      <= w_code_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_drop      <= w_drop_nxt;
            r_frame_cnt <= r_frame_cnt + 16'(w_cnt_inc);
        end
    end

`ifdef PCS_ENC4B5B_NRZI_EN
    // NRZI stage: the line toggles on every 1, walking lane 0 bit 4 first.
    logic                 r_line;
    logic [5*LANES-1:0]   r_nrzi;
    logic                 r_busy_d;
    logic                 r_drop_d;
    logic [15:0]          r_frame_cnt_d;
    logic [5*LANES-1:0]   w_nrzi;
    logic                 w_line_end;

    always_comb begin
        logic v_line;
        v_line = r_line;
        w_nrzi = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 4; b >= 0; b--) begin
                v_line = v_line ^ r_code[5*l + b];
                w_nrzi[5*l + b] = v_line;
            end
        end
        w_line_end = v_line;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_line        <= 1'b0;
            r_nrzi        <= '0;
            r_busy_d      <= 1'b0;
            r_drop_d      <= 1'b0;
            r_frame_cnt_d <= '0;
        end else begin
            r_line        <= w_line_end;
            r_nrzi        <= w_nrzi;
            r_busy_d      <= r_busy;
            r_drop_d      <= r_drop;
            r_frame_cnt_d <= r_frame_cnt;
        end
    end

    assign o_data      = r_nrzi;
    assign o_busy      = r_busy_d;
    assign o_drop      = r_drop_d;
    assign o_frame_cnt = r_frame_cnt_d;
`else
    assign o_data      = r_code;
    assign o_busy      = r_busy;
    assign o_drop      = r_drop;
    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_pcs_enc4b5b.sv
// -----------------------------------------------------------------------------
// tb_pcs_enc4b5b -- directed bench for pcs_enc4b5b.
// u_l1: LANES=1, MIN_IPG=24.  u_l2: LANES=2, MIN_IPG=0.
// Inputs change 1 ns after a rising edge; outputs are sampled at that time,
// so each sample shows the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_pcs_enc4b5b;

    localparam logic [4:0] C_I = 5'b11111;
    localparam logic [4:0] C_J = 5'b11000;
    localparam logic [4:0] C_K = 5'b10001;
    localparam logic [4:0] C_T = 5'b01101;
    localparam logic [4:0] C_R = 5'b00111;
    localparam logic [4:0] C_H = 5'b00100;

    logic        clk;
    logic        res;
    logic        tx_en1, tx_er1;
    logic [3:0]  data1;
    logic [4:0]  out1;
    logic        busy1, drop1;
    logic [15:0] cnt1;
    logic        tx_en2, tx_er2;
    logic [7:0]  data2;
    logic [9:0]  out2;
    logic        busy2, drop2;
    logic [15:0] cnt2;

    int checks = 0;
    int errors = 0;

    pcs_enc4b5b #(.LANES(1), .MIN_IPG(24)) u_l1 (
        .i_clk(clk), .i_res(res), .i_tx_en(tx_en1), .i_tx_er(tx_er1),
        .i_data(data1), .o_data(out1), .o_busy(busy1), .o_drop(drop1),
        .o_frame_cnt(cnt1)
    );

    pcs_enc4b5b #(.LANES(2), .MIN_IPG(0)) u_l2 (
        .i_clk(clk), .i_res(res), .i_tx_en(tx_en2), .i_tx_er(tx_er2),
        .i_data(data2), .o_data(out2), .o_busy(busy2), .o_drop(drop2),
        .o_frame_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle1(input int n);
        tx_en1 = 1'b0;
        for (int i = 0; i < n; i++) tick;
    endtask

`ifdef PCS_ENC4B5B_NRZI_EN
    task automatic test_nrzi;
        logic [4:0] w_pre, w_j, w_k;
        logic       l;
        res = 1'b1; tick; tick;
        checks++;
        if (out1 !== 5'b00000) begin errors++; $display("FAIL nrzi_reset got %b exp 00000", out1); end
        res = 1'b0;
        idle1(4);
        tx_en1 = 1'b1; data1 = 4'h5; tick;     // edge s: J registered
        w_pre = out1;
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL nrzi_busy_delay got %b exp 0", busy1); end
        tick;                                   // edge s+1: NRZI(J) visible
        w_j = out1;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL nrzi_busy got %b exp 1", busy1); end
        tick;                                   // edge s+2: NRZI(K) visible
        w_k = out1;
        l = w_j[3];
        checks++;
        if (w_j !== 5'b10000 && w_j !== 5'b01111) begin errors++; $display("FAIL nrzi_j got %b exp 10000 or 01111", w_j); end
        checks++;
        if (w_pre !== {l, ~l, l, ~l, l}) begin errors++; $display("FAIL nrzi_idle got %b exp %b", w_pre, {l, ~l, l, ~l, l}); end
        checks++;
        if (w_k !== {~l, ~l, ~l, ~l, l}) begin errors++; $display("FAIL nrzi_k got %b exp %b", w_k, {~l, ~l, ~l, ~l, l}); end
        idle1(4);
    endtask
`else
    task automatic test_reset;
        res = 1'b1; tick; tick;
        checks++;
        if (out1 !== C_I) begin errors++; $display("FAIL reset_data1 got %b exp %b", out1, C_I); end
        checks++;
        if ({busy1, drop1} !== 2'b00) begin errors++; $display("FAIL reset_flags1 got %b exp 00", {busy1, drop1}); end
        checks++;
        if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
        checks++;
        if (out2 !== {C_I, C_I}) begin errors++; $display("FAIL reset_data2 got %b exp %b", out2, {C_I, C_I}); end
        res = 1'b0;
        tick;
    endtask

    // 16 nibbles 5..5,D -> J,K,13x5,D,T,R
    task automatic test_frame_l1;
        logic [4:0] exp;
        for (int k = 0; k < 16; k++) begin
            tx_en1 = 1'b1; data1 = (k == 15) ? 4'hD : 4'h5; tick;
            exp = (k == 0) ? C_J : (k == 1) ? C_K : (k == 15) ? 5'b11011 : 5'b01011;
            checks++;
            if (out1 !== exp) begin errors++; $display("FAIL frame_l1[%0d] got %b exp %b", k, out1, exp); end
            if (k == 0) begin
                checks++;
                if (busy1 !== 1'b1) begin errors++; $display("FAIL frame_l1_busy got %b exp 1", busy1); end
            end
        end
        tx_en1 = 1'b0; tick;
        checks++;
        if (out1 !== C_T) begin errors++; $display("FAIL frame_l1_t got %b exp %b", out1, C_T); end
        tick;
        checks++;
        if (out1 !== C_R) begin errors++; $display("FAIL frame_l1_r got %b exp %b", out1, C_R); end
        checks++;
        if (cnt1 !== 16'd1) begin errors++; $display("FAIL frame_l1_cnt got %0d exp 1", cnt1); end
        tick;
        checks++;
        if (out1 !== C_I) begin errors++; $display("FAIL frame_l1_idle got %b exp %b", out1, C_I); end
    endtask

    // Nibbles 0..7, TX_ER on nibble 6 -> J,K,2,3,4,5,H,7,T,R
    task automatic test_tx_er;
        logic [4:0] exp [8];
        exp = '{C_J, C_K, 5'b10100, 5'b10101, 5'b01010, 5'b01011, C_H, 5'b01111};
        idle1(30);
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL tx_er_pre_busy got %b exp 0", busy1); end
        for (int k = 0; k < 8; k++) begin
            tx_en1 = 1'b1; tx_er1 = (k == 6); data1 = 4'(k); tick;
            checks++;
            if (out1 !== exp[k]) begin errors++; $display("FAIL tx_er[%0d] got %b exp %b", k, out1, exp[k]); end
        end
        tx_er1 = 1'b0; tx_en1 = 1'b0; tick;
        checks++;
        if (out1 !== C_T) begin errors++; $display("FAIL tx_er_t got %b exp %b", out1, C_T); end
        tick;
        checks++;
        if (out1 !== C_R) begin errors++; $display("FAIL tx_er_r got %b exp %b", out1, C_R); end
        checks++;
        if (cnt1 !== 16'd2) begin errors++; $display("FAIL tx_er_cnt got %0d exp 2", cnt1); end
    endtask

    // Start 10 idles after R -> dropped; later frame after long gap is sent.
    task automatic test_ipg_drop;
        int n_drop;
        int n_bad;
        logic [4:0] exp [4];
        exp = '{C_J, C_K, 5'b10011, 5'b11100};
        idle1(10);
        n_drop = 0; n_bad = 0;
        for (int k = 0; k < 6; k++) begin
            tx_en1 = 1'b1; data1 = 4'h5; tick;
            if (drop1) n_drop++;
            if (out1 !== C_I) n_bad++;
            if (k == 0) begin
                checks++;
                if (drop1 !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", drop1); end
            end
        end
        tx_en1 = 1'b0; tick;
        if (drop1) n_drop++;
        if (out1 !== C_I) n_bad++;
        checks++;
        if (n_drop !== 1) begin errors++; $display("FAIL drop_count got %0d exp 1", n_drop); end
        checks++;
        if (n_bad !== 0) begin errors++; $display("FAIL drop_data non-idle cycles got %0d exp 0", n_bad); end
        checks++;
        if (cnt1 !== 16'd2) begin errors++; $display("FAIL drop_cnt got %0d exp 2", cnt1); end
        idle1(24);
        for (int k = 0; k < 4; k++) begin
            tx_en1 = 1'b1; data1 = (k == 2) ? 4'h9 : (k == 3) ? 4'hE : 4'h5; tick;
            checks++;
            if (out1 !== exp[k]) begin errors++; $display("FAIL after_drop[%0d] got %b exp %b", k, out1, exp[k]); end
        end
        tx_en1 = 1'b0; tick;
        checks++;
        if (out1 !== C_T) begin errors++; $display("FAIL after_drop_t got %b exp %b", out1, C_T); end
        tick;
        checks++;
        if (out1 !== C_R) begin errors++; $display("FAIL after_drop_r got %b exp %b", out1, C_R); end
        checks++;
        if (cnt1 !== 16'd3) begin errors++; $display("FAIL after_drop_cnt got %0d exp 3", cnt1); end
    endtask

    // Start after 23 idles -> drop; start after exactly 24 idles -> J.
    task automatic test_min_restart;
        idle1(23);
        tx_en1 = 1'b1; data1 = 4'h5; tick;
        checks++;
        if ({drop1, out1} !== {1'b1, C_I}) begin errors++; $display("FAIL restart_23 got drop=%b data=%b exp drop=1 data=%b", drop1, out1, C_I); end
        tick;
        idle1(40);
        tx_en1 = 1'b1; tick; tick; data1 = 4'h0; tick;
        tx_en1 = 1'b0; tick;
        tick;
        checks++;
        if (out1 !== C_R) begin errors++; $display("FAIL restart_setup_r got %b exp %b", out1, C_R); end
        idle1(24);
        tx_en1 = 1'b1; data1 = 4'h5; tick;
        checks++;
        if ({drop1, out1} !== {1'b0, C_J}) begin errors++; $display("FAIL restart_24 got drop=%b data=%b exp drop=0 data=%b", drop1, out1, C_J); end
        checks++;
        if (cnt1 !== 16'd5) begin errors++; $display("FAIL restart_cnt got %0d exp 5", cnt1); end
        tick; tick;
        tx_en1 = 1'b0; tick; tick;
        idle1(30);
    endtask

    // 8-byte frame on two lanes: {K,J}, 7 data bytes, {R,T}; busy 9 cycles.
    task automatic test_lanes2;
        logic [7:0] bytes [8];
        logic [9:0] exp [8];
        int n_busy;
        bytes = '{8'h55, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hFE};
        exp = '{{C_K, C_J}, 10'b01001_11110, 10'b10101_10100, 10'b01011_01010,
                10'b01111_01110, 10'b10011_10010, 10'b10111_10110, 10'b11101_11100};
        n_busy = 0;
        for (int k = 0; k < 8; k++) begin
            tx_en2 = 1'b1; data2 = bytes[k]; tick;
            if (busy2) n_busy++;
            checks++;
            if (out2 !== exp[k]) begin errors++; $display("FAIL lanes2[%0d] got %b exp %b", k, out2, exp[k]); end
        end
        tx_en2 = 1'b0; tick;
        if (busy2) n_busy++;
        checks++;
        if (out2 !== {C_R, C_T}) begin errors++; $display("FAIL lanes2_end got %b exp %b", out2, {C_R, C_T}); end
        for (int k = 0; k < 4; k++) begin
            tick;
            if (busy2) n_busy++;
        end
        checks++;
        if (n_busy !== 9) begin errors++; $display("FAIL lanes2_busy cycles got %0d exp 9", n_busy); end
        checks++;
        if (cnt2 !== 16'd1) begin errors++; $display("FAIL lanes2_cnt got %0d exp 1", cnt2); end
    endtask

    // MIN_IPG=0: restart straight after {R,T} is accepted.
    task automatic test_back_to_back;
        tx_en2 = 1'b1; data2 = 8'h55; tick;
        data2 = 8'h21; tick;
        checks++;
        if (out2 !== 10'b10100_01001) begin errors++; $display("FAIL b2b_data got %b exp 1010001001", out2); end
        tx_en2 = 1'b0; tick;
        checks++;
        if (out2 !== {C_R, C_T}) begin errors++; $display("FAIL b2b_end got %b exp %b", out2, {C_R, C_T}); end
        tx_en2 = 1'b1; data2 = 8'h55; tick;
        checks++;
        if ({drop2, out2} !== {1'b0, C_K, C_J}) begin errors++; $display("FAIL b2b_restart got drop=%b data=%b exp drop=0 data=%b", drop2, out2, {C_K, C_J}); end
        checks++;
        if (cnt2 !== 16'd3) begin errors++; $display("FAIL b2b_cnt got %0d exp 3", cnt2); end
        tx_en2 = 1'b0; tick; tick; tick;
    endtask

    // tx_en high across reset release; reset asserted mid-DATA.
    task automatic test_reset_mid_frame;
        int n_bad;
        res = 1'b1; tx_en1 = 1'b1; data1 = 4'h5; tick; tick;
        res = 1'b0;
        n_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (out1 !== C_I || busy1 !== 1'b0) n_bad++;
        end
        checks++;
        if (n_bad !== 0) begin errors++; $display("FAIL en_at_release non-idle cycles got %0d exp 0", n_bad); end
        tx_en1 = 1'b0; tick;
        tx_en1 = 1'b1; tick;
        checks++;
        if (out1 !== C_J) begin errors++; $display("FAIL en_rise got %b exp %b", out1, C_J); end
        tick; data1 = 4'h3; tick;
        checks++;
        if (out1 !== 5'b10101) begin errors++; $display("FAIL mid_frame_data got %b exp 10101", out1); end
        res = 1'b1; tick;
        checks++;
        if ({busy1, out1} !== {1'b0, C_I}) begin errors++; $display("FAIL mid_reset got busy=%b data=%b exp busy=0 data=%b", busy1, out1, C_I); end
        checks++;
        if (cnt1 !== 16'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d exp 0", cnt1); end
        res = 1'b0; tx_en1 = 1'b0;
        n_bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (out1 !== C_I) n_bad++;
        end
        checks++;
        if (n_bad !== 0) begin errors++; $display("FAIL no_tr_after_reset non-idle cycles got %0d exp 0", n_bad); end
    endtask
`endif

    initial begin
        res = 1'b1;
        tx_en1 = 1'b0; tx_er1 = 1'b0; data1 = 4'h0;
        tx_en2 = 1'b0; tx_er2 = 1'b0; data2 = 8'h00;
`ifdef PCS_ENC4B5B_NRZI_EN
        test_nrzi;
`else
        test_reset;
        test_frame_l1;
        test_tx_er;
        test_ipg_drop;
        test_min_restart;
        test_lanes2;
        test_back_to_back;
        test_reset_mid_frame;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
